// File: rtl/iq_dispatch_ctrl.sv
// Occupancy/credit controller for the 4-in/1-out issue queue: all-or-nothing group
// dispatch, issue drain and branch-kill recovery. Optional stall counter: IQ_DISP_PERF_CNT_EN.
module iq_dispatch_ctrl #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned DISP_W    = 4,
  parameter int unsigned WIDTH_CNT = 6,
  parameter int unsigned RECOV_CYC = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [3:0]           i_disp_valid,
  output logic                 o_disp_ready,
  output logic                 o_q_en,
  input  logic                 i_issue,
  input  logic                 i_kill,
  input  logic [WIDTH_CNT-1:0] i_kill_cnt,
  output logic [WIDTH_CNT-1:0] o_count,
  output logic                 o_empty,
`ifdef IQ_DISP_PERF_CNT_EN
  output logic                 o_full,
  output logic [31:0]          o_stall_cnt
`else
  output logic                 o_full
`endif
);

  localparam int unsigned EW = WIDTH_CNT + 1;
  localparam int unsigned RW = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_BLOCK   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [RW-1:0]        r_rcnt;
  logic [RW-1:0]        w_rcnt_next;
  logic [WIDTH_CNT-1:0] r_count;
  logic [WIDTH_CNT-1:0] w_count_next;
  logic                 r_empty;
  logic                 r_full;

  logic [EW-1:0]        w_n;
  logic [EW-1:0]        w_free;
  logic [EW-1:0]        w_sub;
  logic [EW-1:0]        w_free_next;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_iss;
  state_t               w_class;

  // Lane popcount and credit check use only the registered occupancy.
  assign w_n      = EW'(i_disp_valid[0]) + EW'(i_disp_valid[1])
                  + EW'(i_disp_valid[2]) + EW'(i_disp_valid[3]);
  assign w_free   = EW'(SIZE) - EW'(r_count);
  assign w_ready  = (r_state != S_RECOVER) && (w_free >= EW'(DISP_W)) && !i_kill;
  assign w_accept = w_ready && (|i_disp_valid);
  assign w_iss    = i_issue && (r_count != '0);
  assign w_sub    = EW'(w_iss) + EW'(i_kill_cnt);

  // Next occupancy; a kill saturates at zero instead of wrapping.
  always_comb begin
    w_count_next = r_count;
    if (i_kill) begin
      if (EW'(r_count) >= w_sub) begin
        w_count_next = WIDTH_CNT'(EW'(r_count) - w_sub);
      end else begin
        w_count_next = '0;
      end
    end else begin
      w_count_next = WIDTH_CNT'(EW'(r_count) + (w_accept ? w_n : EW'(0)) - EW'(w_iss));
    end
  end

  // Steady-state class derived from the next occupancy.
  assign w_free_next = EW'(SIZE) - EW'(w_count_next);
  always_comb begin
    w_class = S_RUN;
    if (w_count_next == '0) begin
      w_class = S_IDLE;
    end else if (w_free_next < EW'(DISP_W)) begin
      w_class = S_BLOCK;
    end
  end

  // Next-state logic: kill wins, then recovery countdown, then occupancy class.
  always_comb begin
    w_state_next = w_class;
    w_rcnt_next  = r_rcnt;
    if (i_kill) begin
      w_state_next = S_RECOVER;
      w_rcnt_next  = RW'(RECOV_CYC);
    end else if (r_state == S_RECOVER) begin
      if (r_rcnt != '0) begin
        w_rcnt_next = r_rcnt - RW'(1);
      end
      if (r_rcnt > RW'(1)) begin
        w_state_next = S_RECOVER;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == WIDTH_CNT'(SIZE));
    end
  end

  assign o_disp_ready = w_ready;
  assign o_q_en       = w_accept;
  assign o_count      = r_count;
  assign o_empty      = r_empty;
  assign o_full       = r_full;

`ifdef IQ_DISP_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts every cycle with pending lanes that were not accepted, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if ((|i_disp_valid) && !w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_iq_dispatch_ctrl.sv
// Directed, table-driven bench for iq_dispatch_ctrl (default SIZE=32, RECOV_CYC=1).
module tb_iq_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic       ready;
  logic       qen;
  logic       issue;
  logic       kill;
  logic [5:0] kcnt;
  logic [5:0] count;
  logic       empty;
  logic       full;
`ifdef IQ_DISP_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  iq_dispatch_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_disp_valid (valid),
    .o_disp_ready (ready),
    .o_q_en       (qen),
    .i_issue      (issue),
    .i_kill       (kill),
    .i_kill_cnt   (kcnt),
    .o_count      (count),
    .o_empty      (empty),
`ifdef IQ_DISP_PERF_CNT_EN
    .o_full       (full),
    .o_stall_cnt  (stall_cnt)
`else
    .o_full       (full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       issue;
    logic       kill;
    logic [5:0] kcnt;
    logic       rdy;
    logic       qen;
    logic [5:0] cnt;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic is,
                              input logic k, input logic [5:0] kc, input logic rd,
                              input logic qe, input logic [5:0] c, input logic e,
                              input logic f);
    vec_t t;
    t.rst = r; t.valid = v; t.issue = is; t.kill = k; t.kcnt = kc;
    t.rdy = rd; t.qen = qe; t.cnt = c; t.emp = e; t.ful = f;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = '0; issue = 1'b0; kill = 1'b0; kcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", -1, 32'(count), 32'd0);
    chk("rst_empty", -1, 32'(empty), 32'd1);
    chk("rst_full",  -1, 32'(full),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", -1, 32'(ready), 32'd1);
    chk("rst_qen",   -1, 32'(qen),   32'd0);

    // Fill with full groups: 0 -> 32, then blocked at full.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 1, 1, 6'((i + 1) * 4), 0, (i == 7)));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 32, 0, 1));
    // Drain to 30, then single lane with free=2 is refused.
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 31, 0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 30, 0, 0));
    vecs.push_back(mk(0, 4'h1, 1, 0, 0, 0, 0, 29, 0, 0));
    // Kill down to 10, one recovery cycle, then two-lane group with issue.
    vecs.push_back(mk(0, 4'h0, 0, 1, 19, 0, 0, 10, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 10, 0, 0));
    vecs.push_back(mk(0, 4'h5, 1, 0, 0, 1, 1, 11, 0, 0));
    vecs.push_back(mk(0, 4'h1, 0, 0, 0, 1, 1, 12, 0, 0));
    // Oversized kill saturates at 0; recovery blocks dispatch once.
    vecs.push_back(mk(0, 4'hF, 0, 1, 20, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 0, 1, 0));
    // Issue on empty queue is ignored.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 0, 1, 0));
    // Kill with issue, then kill inside RECOVER reloads the counter.
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 1, 1, 8, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 1, 2, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 4, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 4, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 1, 1, 8, 0, 0));
    // Reset mid-recovery overrides a simultaneous kill.
    vecs.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 7, 0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 1, 1, 4, 0, 0));
    // Sparse lane patterns.
    vecs.push_back(mk(0, 4'hA, 0, 0, 0, 1, 1, 6, 0, 0));
    vecs.push_back(mk(0, 4'h7, 1, 0, 0, 1, 1, 8, 0, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 7, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; valid = vecs[i].valid; issue = vecs[i].issue;
      kill = vecs[i].kill; kcnt = vecs[i].kcnt;
      #1;
      chk("ready", i, 32'(ready), 32'(vecs[i].rdy));
      chk("q_en",  i, 32'(qen),   32'(vecs[i].qen));
      @(posedge clk);
      #1;
      chk("count", i, 32'(count), 32'(vecs[i].cnt));
      chk("empty", i, 32'(empty), 32'(vecs[i].emp));
      chk("full",  i, 32'(full),  32'(vecs[i].ful));
    end

`ifdef IQ_DISP_PERF_CNT_EN
    // Five kill-blocked cycles with lanes pending, then reset clears the counter.
    @(negedge clk);
    rst = 1'b1; valid = '0; issue = 1'b0; kill = 1'b0; kcnt = '0;
    @(negedge clk);
    rst = 1'b0; valid = 4'hF; kill = 1'b1;
    repeat (5) @(negedge clk);
    valid = '0; kill = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_cnt", -2, stall_cnt, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_rst", -2, stall_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
